// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bus between decode/write-back (master) and the register file with
//   pending-write scoreboard (slave).
//   Write-back : WEN, wsel, wdat
//   Read ports : rsel1/rsel2 -> rdat1/rdat2 (combinational, with bypass)
//   Issue      : iss_valid, iss_wen, iss_wsel, iss_use1, iss_use2 -> stall
//   Cancel     : cnl_valid, cnl_wsel
//   Status     : err (sticky counter underflow/overflow)
interface regfile_scoreboard_if #(
  parameter int DW = 32
);
  logic          WEN;
  logic [4:0]    wsel;
  logic [DW-1:0] wdat;
  logic [4:0]    rsel1;
  logic [4:0]    rsel2;
  logic [DW-1:0] rdat1;
  logic [DW-1:0] rdat2;
  logic          iss_valid;
  logic          iss_wen;
  logic [4:0]    iss_wsel;
  logic          iss_use1;
  logic          iss_use2;
  logic          stall;
  logic          cnl_valid;
  logic [4:0]    cnl_wsel;
  logic          err;

  modport master (
    output WEN, wsel, wdat, rsel1, rsel2,
    output iss_valid, iss_wen, iss_wsel, iss_use1, iss_use2,
    output cnl_valid, cnl_wsel,
    input  rdat1, rdat2, stall, err
  );

  modport slave (
    input  WEN, wsel, wdat, rsel1, rsel2,
    input  iss_valid, iss_wen, iss_wsel, iss_use1, iss_use2,
    input  cnl_valid, cnl_wsel,
    output rdat1, rdat2, stall, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file (register 0 hardwired to zero) with write-through read
//   bypass and a per-register count of issued-but-not-written-back writers.
//   Decode is told to stall on RAW hazards or when a destination counter is
//   saturated.
// Ports
//   CLK : clock, all state updates on rising edge
//   RST : synchronous active-high reset
//   bus : regfile_scoreboard_if.slave (write-back, reads, issue, cancel, err)
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int CW    = 2
) (
  input logic                  CLK,
  input logic                  RST,
  regfile_scoreboard_if.slave  bus
);

  // One extra bit so cnt + inc cannot wrap before the dec compare.
  localparam int XW = CW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DW-1:0] regs    [NREGS];
  logic [CW-1:0] cnt     [NREGS];
  logic [CW-1:0] cnt_nxt [NREGS];
  logic [1:0]    dec     [NREGS];
  logic          busy    [NREGS];
  logic [NREGS-1:0] bad;

  logic haz1, haz2, full, accept;
  logic err_q;

  // Effective busy: pending count after this cycle's write-back/cancel.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r]  = 2'(bus.WEN && (bus.wsel == 5'(r)))
              + 2'(bus.cnl_valid && (bus.cnl_wsel == 5'(r)));
      busy[r] = XW'(cnt[r]) > XW'(dec[r]);
    end
  end

  always_comb begin
    haz1   = bus.iss_use1 && (bus.rsel1 != '0) && busy[bus.rsel1];
    haz2   = bus.iss_use2 && (bus.rsel2 != '0) && busy[bus.rsel2];
    // Full looks at the raw count: a same-cycle write-back does not free a slot.
    full   = bus.iss_wen && (bus.iss_wsel != '0) && (cnt[bus.iss_wsel] == CNT_MAX);
    bus.stall = bus.iss_valid && (haz1 || haz2 || full);
    accept = bus.iss_valid && !bus.stall;
  end

  always_comb begin
    if (bus.rsel1 == '0)
      bus.rdat1 = '0;
    else if (bus.WEN && (bus.wsel == bus.rsel1))
      bus.rdat1 = bus.wdat;
    else
      bus.rdat1 = regs[bus.rsel1];

    if (bus.rsel2 == '0)
      bus.rdat2 = '0;
    else if (bus.WEN && (bus.wsel == bus.rsel2))
      bus.rdat2 = bus.wdat;
    else
      bus.rdat2 = regs[bus.rsel2];
  end

  always_comb begin
    logic          inc;
    logic [XW-1:0] sum;
    logic [XW-1:0] res;
    for (int r = 0; r < NREGS; r++) begin
      inc        = accept && bus.iss_wen && (bus.iss_wsel == 5'(r));
      sum        = XW'(cnt[r]) + XW'(inc);
      res        = '0;
      cnt_nxt[r] = '0;
      bad[r]     = 1'b0;
      if (r != 0) begin
        if (XW'(dec[r]) > sum) begin
          bad[r] = 1'b1;
        end else begin
          res = sum - XW'(dec[r]);
          if (res > XW'(CNT_MAX)) begin
            cnt_nxt[r] = CNT_MAX;
            bad[r]     = 1'b1;
          end else begin
            cnt_nxt[r] = CW'(res);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (bus.WEN && (bus.wsel != '0))
        regs[bus.wsel] <= bus.wdat;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= cnt_nxt[r];
      err_q <= err_q | (|bad);
    end
  end

  assign bus.err = err_q;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register file with an integrated pending-write scoreboard: the receiving end of the write-back port (WEN/wsel/wdat). It also serves the two decode-stage read ports, with write-through bypass. For each register it tracks how many issued instructions still owe a write, and tells decode when an issuing instruction must stall on a RAW hazard. Sits between the decode stage (reads, issue) and the write-back stage (writes, completion).

## Interface
- NREGS, 32, number of architectural registers; register 0 hardwired to zero
- DW, 32, data width
- CW, 2, pending-counter width per register (max in-flight writers = 2^CW − 1)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- WEN  in  1  write-back write enable
- wsel  in  5  write-back destination register
- wdat  in  DW  write-back data
- rsel1  in  5  read port 1 select
- rsel2  in  5  read port 2 select
- rdat1  out  DW  read port 1 data (combinational)
- rdat2  out  DW  read port 2 data (combinational)
- iss_valid  in  1  decode requests issue of an instruction
- iss_wen  in  1  issuing instruction writes a register
- iss_wsel  in  5  issuing instruction's destination
- iss_use1  in  1  issuing instruction reads rsel1
- iss_use2  in  1  issuing instruction reads rsel2
- stall  out  1  issue refused this cycle
- cnl_valid  in  1  squashed instruction will never write back
- cnl_wsel  in  5  its destination
- err  out  1  sticky: counter underflow or overflow attempted

## Operation
- Storage: NREGS×DW array; cnt[r] is CW bits. Register 0 reads 0, ignores writes, and its cnt stays 0.
- Write: on the edge with WEN=1 and wsel≠0, reg[wsel] ← wdat.
- Read bypass: rdatN = wdat if WEN=1 and wsel=rselN≠0; 0 if rselN=0; else reg[rselN].
- Hazard, per port N, excluding register 0:
  - hazN = iss_useN ∧ rselN≠0 ∧ eff[rselN]>0
  - eff[r] = cnt[r] − (WEN ∧ wsel=r) − (cnl_valid ∧ cnl_wsel=r), saturating at 0
  - A write-back arriving this cycle therefore releases the hazard, and the bypass supplies the data.
- Full: full = iss_wen ∧ iss_wsel≠0 ∧ cnt[iss_wsel]=2^CW−1.
- Stall: stall = iss_valid ∧ (haz1 ∨ haz2 ∨ full).
- Accept: accept = iss_valid ∧ ¬stall.
- Counter update per r≠0, every edge: cnt[r] ← cnt[r] + inc − dec
  - inc = accept ∧ iss_wen ∧ iss_wsel=r
  - dec = (WEN ∧ wsel=r) + (cnl_valid ∧ cnl_wsel=r), range 0..2
  - Simultaneous inc and dec on the same register net out.
- Underflow: if dec > cnt[r] + inc, cnt[r] ← 0 and err ← 1.
  - A write-back to an untracked register (cnt=0, no inc) still writes data but sets err.
- err is cleared only by RST.

## Timing
- Reset (synchronous): all reg = 0, all cnt = 0, err = 0. With stable inputs, rdat1/rdat2 = 0 and stall = 0 in the cycle after reset.
- RST asserted mid-operation: all state cleared on that edge. WEN, issue and cancel in the same cycle are ignored.
- Write latency: 0 cycles via bypass, 1 cycle via the array.
- Scoreboard latency: an accepted issue in cycle t makes the register busy for issue checks from cycle t+1.
- stall is purely combinational from the current inputs and cnt; there is no registered output path.
- Decode must hold the issue inputs while stall=1; the block keeps no issue state.

## Test plan
- Reset/read: assert RST for 2 cycles, then read r0..r31 → all 0, stall=0, err=0.
- Write + bypass: WEN=1, wsel=5, wdat=0xDEADBEEF with rsel1=5 in the same cycle → rdat1=0xDEADBEEF that cycle and from the array next cycle. wsel=0, wdat=0x1 → rdat of r0 stays 0.
- RAW stall and release:
  - Issue iss_wsel=7 (accepted), then next cycle issue with rsel1=7, iss_use1=1 → stall=1.
  - When WEN=1, wsel=7, wdat=0x42 arrives → stall=0 that cycle, rdat1=0x42, cnt[7]=0 after the edge.
- Multiple writers: issue wsel=3 three times → cnt[3]=3. A fourth issue to 3 → stall=1 (full). A write-back to 3 in the same cycle as an accepted issue leaves cnt[3] unchanged.
- Cancel: issue wsel=9, then cnl_valid=1, cnl_wsel=9 → cnt[9]=0 and a later read of 9 does not stall. WEN and cnl to 9 together when cnt[9]=2 → cnt[9]=0.
- Error: WEN=1, wsel=12 with cnt[12]=0 → reg[12] written, err=1 and stays 1 until RST.
